// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM stage of the 16-bit pipelined CPU.
// Performs loads/stores over a req/ack handshake, stalls upstream while an
// access is outstanding, and registers writeback fields toward MEM/WB.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort requests that are
// not acknowledged within TIMEOUT_CYCLES cycles (sets sticky mem_err).
module memory_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        wbs_in,
   input  logic [1:0]  mm_in,
   input  logic        wm_in,
   input  logic [15:0] alu_result_in,
   input  logic [15:0] mem_data_in,
   input  logic [3:0]  reg_dest_in,
   input  logic        wre_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic        wb_wre,
   output logic [3:0]  wb_rd,
   output logic [15:0] wb_data,
   output logic        mem_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   logic [0:0]  state_reg;
   logic [15:0] addr_reg;
   logic [15:0] wdata_reg;
   logic [1:0]  mm_reg;
   logic        we_reg;
   logic        wbs_reg;
   logic        wre_reg;
   logic [3:0]  rd_reg;
   logic        abort;
   logic        is_store;
   logic        is_load;
   logic        is_access;
   logic [15:0] load_data;

   // A store takes priority; a load flagged together with a store is dropped.
   assign is_store  = wm_in;
   assign is_load   = (mm_in != 2'b00) && !wm_in;
   assign is_access = is_store || is_load;

   assign mem_req   = (state_reg == REQ);
   assign mem_we    = we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [7:0] cnt_reg;
   logic       err_reg;

   // Abort on the last allowed REQ cycle unless the ack arrives in it.
   assign abort   = (state_reg == REQ) && !mem_ack &&
                    (cnt_reg == 8'(TIMEOUT_CYCLES - 1));
   assign mem_err = err_reg;

   // Wait counter cleared on REQ entry; error flag sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 8'd0;
         err_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE && in_valid && is_access)
            cnt_reg <= 8'd0;
         else if (state_reg == REQ && !mem_ack)
            cnt_reg <= cnt_reg + 8'd1;
         if (abort)
            err_reg <= 1'b1;
      end
   end
`else
   assign abort   = 1'b0;
   assign mem_err = 1'b0;
`endif

   // Stall while a new access is being accepted or a request awaits its ack.
   always_comb begin
      stall = 1'b0;
      if (rst_n) begin
         if (state_reg == IDLE)
            stall = in_valid && is_access;
         else
            stall = !mem_ack && !abort;
      end
   end

   // Extract the loaded value according to the captured load mode.
   always_comb begin
      load_data = mem_rdata;
      case (mm_reg)
         2'b10:   load_data = {8'h00, mem_rdata[7:0]};
         2'b11:   load_data = {8'h00, mem_rdata[15:8]};
         default: load_data = mem_rdata;
      endcase
   end

   // Stage FSM: capture access fields, run the handshake, register writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         addr_reg  <= 16'h0000;
         wdata_reg <= 16'h0000;
         mm_reg    <= 2'b00;
         we_reg    <= 1'b0;
         wbs_reg   <= 1'b0;
         wre_reg   <= 1'b0;
         rd_reg    <= 4'h0;
         wb_valid  <= 1'b0;
         wb_wre    <= 1'b0;
         wb_rd     <= 4'h0;
         wb_data   <= 16'h0000;
      end else begin
         wb_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  if (is_access) begin
                     addr_reg  <= alu_result_in;
                     wdata_reg <= mem_data_in;
                     mm_reg    <= mm_in;
                     we_reg    <= is_store;
                     wbs_reg   <= wbs_in;
                     wre_reg   <= wre_in;
                     rd_reg    <= reg_dest_in;
                     state_reg <= REQ;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_wre   <= wre_in;
                     wb_rd    <= reg_dest_in;
                     wb_data  <= alu_result_in;
                  end
               end
            end
            default: begin
               if (mem_ack) begin
                  state_reg <= IDLE;
                  wb_valid  <= 1'b1;
                  wb_wre    <= wre_reg;
                  wb_rd     <= rd_reg;
                  wb_data   <= (!we_reg && wbs_reg) ? load_data : addr_reg;
               end else if (abort) begin
                  state_reg <= IDLE;
                  wb_valid  <= 1'b1;
                  wb_wre    <= 1'b0;
                  wb_rd     <= rd_reg;
                  wb_data   <= addr_reg;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: table-driven single transactions plus
// hand-written sequences for reset, back-to-back stores and timeout.
module tb_memory_access_stage;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, wbs_in, wm_in, wre_in, mem_ack;
   logic [1:0]  mm_in;
   logic [15:0] alu_result_in, mem_data_in, mem_rdata;
   logic [3:0]  reg_dest_in;
   logic        stall, mem_req, mem_we, wb_valid, wb_wre, mem_err;
   logic [15:0] mem_addr, mem_wdata, wb_data;
   logic [3:0]  wb_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wbs_in(wbs_in),
      .mm_in(mm_in), .wm_in(wm_in), .alu_result_in(alu_result_in),
      .mem_data_in(mem_data_in), .reg_dest_in(reg_dest_in), .wre_in(wre_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .wb_wre(wb_wre), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_err(mem_err)
   );

   typedef struct {
      string       name;
      logic [1:0]  mm;
      logic        wm, wbs, wre;
      logic [15:0] alu, wdata, rdata;
      logic [3:0]  rd;
      int          k;        // ack arrives in REQ cycle k
      logic        exp_acc;
      logic        exp_we;
      logic [15:0] exp_wb;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid      = 1'b1;
      mm_in         = v.mm;
      wm_in         = v.wm;
      wbs_in        = v.wbs;
      wre_in        = v.wre;
      alu_result_in = v.alu;
      mem_data_in   = v.wdata;
      reg_dest_in   = v.rd;
   endtask

   // Apply one instruction starting at the next clock; ends at a negedge.
   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      chk({v.name, ".stall0"}, stall, v.exp_acc);
      if (v.exp_acc) begin
         for (int c = 1; c <= v.k; c++) begin
            @(posedge clk); #1;
            mem_ack   = (c == v.k);
            mem_rdata = (c == v.k) ? v.rdata : 16'hDEAD;
            @(negedge clk);
            chk({v.name, ".req"}, mem_req, 1);
            chk({v.name, ".we"}, mem_we, v.exp_we);
            chk({v.name, ".addr"}, mem_addr, v.alu);
            if (v.exp_we) chk({v.name, ".wdata"}, mem_wdata, v.wdata);
            chk({v.name, ".stall"}, stall, (c != v.k));
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      @(negedge clk);
      chk({v.name, ".wb_valid"}, wb_valid, 1);
      chk({v.name, ".wb_data"}, wb_data, v.exp_wb);
      chk({v.name, ".wb_wre"}, wb_wre, v.wre);
      chk({v.name, ".wb_rd"}, wb_rd, v.rd);
      chk({v.name, ".req_low"}, mem_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({v.name, ".wb_valid_drop"}, wb_valid, 0);
      $display("txn %s wb_data=0x%04h", v.name, wb_data);
   endtask

   initial begin
      //          name        mm     wm    wbs   wre   alu       wdata     rdata     rd    k  acc   we    exp_wb
      vecs[0] = '{"alu",     2'b00, 1'b0, 1'b0, 1'b1, 16'h0BAD, 16'h0000, 16'h0000, 4'd3, 0, 1'b0, 1'b0, 16'h0BAD};
      vecs[1] = '{"ldw",     2'b01, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 4'd2, 3, 1'b1, 1'b0, 16'hBEEF};
      vecs[2] = '{"ldlo",    2'b10, 1'b0, 1'b1, 1'b1, 16'h0041, 16'h0000, 16'hA55A, 4'd4, 1, 1'b1, 1'b0, 16'h005A};
      vecs[3] = '{"ldhi",    2'b11, 1'b0, 1'b1, 1'b1, 16'h0042, 16'h0000, 16'hA55A, 4'd6, 2, 1'b1, 1'b0, 16'h00A5};
      vecs[4] = '{"st",      2'b01, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hCAFE, 16'h7777, 4'd7, 1, 1'b1, 1'b1, 16'h0010};
      vecs[5] = '{"ldalu",   2'b01, 1'b0, 1'b0, 1'b1, 16'h0077, 16'h0000, 16'h1111, 4'd8, 1, 1'b1, 1'b0, 16'h0077};
      vecs[6] = '{"alu2",    2'b00, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'd15,0, 1'b0, 1'b0, 16'hFFFF};

      // Reset with a non-memory instruction already waiting.
      rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
      in_valid = 1'b1; mm_in = 2'b00; wm_in = 1'b0; wbs_in = 1'b0; wre_in = 1'b1;
      alu_result_in = 16'h1234; mem_data_in = 16'h0000; reg_dest_in = 4'd5;
      repeat (2) @(negedge clk);
      chk("rst.stall", stall, 0);
      chk("rst.req", mem_req, 0);
      chk("rst.we", mem_we, 0);
      chk("rst.addr", mem_addr, 0);
      chk("rst.wdata", mem_wdata, 0);
      chk("rst.wb_valid", wb_valid, 0);
      chk("rst.wb_wre", wb_wre, 0);
      chk("rst.wb_rd", wb_rd, 0);
      chk("rst.wb_data", wb_data, 0);
      chk("rst.err", mem_err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst1.stall", stall, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst1.wb_valid", wb_valid, 1);
      chk("rst1.wb_rd", wb_rd, 5);
      chk("rst1.wb_data", wb_data, 16'h1234);
      chk("rst1.stall_after", stall, 0);
      $display("txn reset_release wb_data=0x%04h", wb_data);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Ack outside REQ must be ignored.
      @(posedge clk); #1;
      mem_ack = 1'b1;
      @(negedge clk);
      chk("stray_ack.req", mem_req, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack.wb_valid", wb_valid, 0);
      $display("txn stray_ack");

      // Back-to-back zero-wait stores: one low mem_req cycle between them.
      @(posedge clk); #1;
      drive(vecs[4]);                                   // cycle 0: store A
      @(negedge clk); chk("b2b.stall0", stall, 1);
      @(posedge clk); #1; mem_ack = 1'b1;               // cycle 1: ack A
      @(negedge clk); chk("b2b.req1", mem_req, 1); chk("b2b.stall1", stall, 0);
      @(posedge clk); #1; mem_ack = 1'b0;               // cycle 2: store B
      alu_result_in = 16'h0020; mem_data_in = 16'h5A5A;
      @(negedge clk);
      chk("b2b.req_gap", mem_req, 0);
      chk("b2b.wbA", wb_valid, 1);
      chk("b2b.wbA_data", wb_data, 16'h0010);
      chk("b2b.stall2", stall, 1);
      @(posedge clk); #1; mem_ack = 1'b1;               // cycle 3: ack B
      @(negedge clk);
      chk("b2b.req3", mem_req, 1);
      chk("b2b.addrB", mem_addr, 16'h0020);
      chk("b2b.wdataB", mem_wdata, 16'h5A5A);
      @(posedge clk); #1; mem_ack = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("b2b.wbB", wb_valid, 1);
      chk("b2b.wbB_data", wb_data, 16'h0020);
      $display("txn back_to_back_stores");

      // Reset pulsed in the second REQ cycle, then a normal load.
      @(posedge clk); #1;
      drive(vecs[1]);
      @(posedge clk); #1;                               // REQ cycle 1
      @(negedge clk); chk("rstreq.req1", mem_req, 1);
      @(posedge clk); #1;                               // REQ cycle 2
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("rstreq.req_drop", mem_req, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rstreq.no_wb", wb_valid, 0);
         chk("rstreq.req_low", mem_req, 0);
      end
      $display("txn reset_mid_req");
      run_vec(vecs[2]);

      // Request with no ack at all.
      @(posedge clk); #1;
      drive(vecs[1]);
      begin
`ifdef MEM_ACCESS_TIMEOUT_EN
         for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("to.req", mem_req, 1);
            chk("to.err_low", mem_err, 0);
         end
         @(posedge clk); #1; in_valid = 1'b0;
         @(negedge clk);
         chk("to.req_drop", mem_req, 0);
         chk("to.err", mem_err, 1);
         chk("to.wb_valid", wb_valid, 1);
         chk("to.wb_wre", wb_wre, 0);
         repeat (3) @(negedge clk);
         chk("to.err_sticky", mem_err, 1);
         chk("to.wb_valid_drop", wb_valid, 0);
         $display("txn timeout_abort");
`else
         for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("wait.req", mem_req, 1);
            chk("wait.stall", stall, 1);
            chk("wait.err", mem_err, 0);
         end
         @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 16'h4321;
         @(posedge clk); #1; mem_ack = 1'b0; in_valid = 1'b0;
         @(negedge clk);
         chk("wait.wb_valid", wb_valid, 1);
         chk("wait.wb_data", wb_data, 16'h4321);
         $display("txn long_wait");
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
